// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if -- bus between two RAM requesters, the arbiter and a 32x8
// synchronous-read RAM.
//   Req0/Req1, Addr0/Addr1, Wren0/Wren1, Wdata0/Wdata1 : requester side requests
//   Gnt0/Gnt1, Rdata, Rvalid0/Rvalid1                  : arbiter responses
//   Ram_Addr, Ram_Wren, Ram_Wdata                      : arbiter -> RAM
//   Ram_Rdata                                          : RAM -> arbiter (1-cycle latency)
// Modport slave is the arbiter's view, master is the environment's view.
interface ram_arbiter_if;
  logic       Req0;
  logic       Req1;
  logic [4:0] Addr0;
  logic [4:0] Addr1;
  logic       Wren0;
  logic       Wren1;
  logic [7:0] Wdata0;
  logic [7:0] Wdata1;
  logic [7:0] Ram_Rdata;
  logic       Gnt0;
  logic       Gnt1;
  logic [4:0] Ram_Addr;
  logic       Ram_Wren;
  logic [7:0] Ram_Wdata;
  logic [7:0] Rdata;
  logic       Rvalid0;
  logic       Rvalid1;

  modport slave (
    input  Req0, Req1, Addr0, Addr1, Wren0, Wren1, Wdata0, Wdata1, Ram_Rdata,
    output Gnt0, Gnt1, Ram_Addr, Ram_Wren, Ram_Wdata, Rdata, Rvalid0, Rvalid1
  );

  modport master (
    output Req0, Req1, Addr0, Addr1, Wren0, Wren1, Wdata0, Wdata1, Ram_Rdata,
    input  Gnt0, Gnt1, Ram_Addr, Ram_Wren, Ram_Wdata, Rdata, Rvalid0, Rvalid1
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter -- two-requester arbiter in front of a 32x8 synchronous-read RAM.
// Grants are Moore outputs of an IDLE/G0/G1 FSM. Ties from IDLE go to the
// requester that was not granted most recently; an owner keeps the RAM for at
// most MAX_HOLD consecutive cycles while the other requester waits.
// Ports:
//   Clock  : sole clock, posedge
//   Resetn : synchronous reset, active HIGH (asserted = 1)
//   bus    : ram_arbiter_if.slave (requests, grants, RAM port, read returns)
module ram_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  ram_arbiter_if.slave  bus
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                last_r;      // 1 = requester 1 was granted most recently
  logic [HOLD_W-1:0]   hold_r;
  logic                gnt0_r;
  logic                gnt1_r;
  logic                rvalid0_r;
  logic                rvalid1_r;
  logic                hold_max_s;
  logic                access0_s;
  logic                access1_s;
  logic [4:0]          ram_addr_s;
  logic [7:0]          ram_wdata_s;
  logic                ram_wren_s;

  assign hold_max_s = (hold_r == HOLD_LAST);
  assign access0_s  = gnt0_r & bus.Req0;
  assign access1_s  = gnt1_r & bus.Req1;

  // Next-state selection for the grant FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.Req0 && bus.Req1) begin
          state_nxt_s = last_r ? G0 : G1;
        end else if (bus.Req0) begin
          state_nxt_s = G0;
        end else if (bus.Req1) begin
          state_nxt_s = G1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      G0: begin
        // The waiting requester takes over when the owner lets go or its
        // hold budget is spent.
        if (bus.Req1 && (!bus.Req0 || hold_max_s)) begin
          state_nxt_s = G1;
        end else if (bus.Req0) begin
          state_nxt_s = G0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      G1: begin
        if (bus.Req0 && (!bus.Req1 || hold_max_s)) begin
          state_nxt_s = G0;
        end else if (bus.Req1) begin
          state_nxt_s = G1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, grant outputs, fairness/hold bookkeeping and read-valid pulses.
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_r   <= IDLE;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      last_r    <= 1'b1;
      hold_r    <= {HOLD_W{1'b0}};
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      gnt0_r  <= (state_nxt_s == G0);
      gnt1_r  <= (state_nxt_s == G1);

      if (state_nxt_s != state_r) begin
        hold_r <= {HOLD_W{1'b0}};
      end else if (!hold_max_s) begin
        hold_r <= hold_r + HOLD_W'(1);
      end else begin
        hold_r <= hold_r;
      end

      if ((state_nxt_s == G0) && (state_r != G0)) begin
        last_r <= 1'b0;
      end else if ((state_nxt_s == G1) && (state_r != G1)) begin
        last_r <= 1'b1;
      end else begin
        last_r <= last_r;
      end

      // RAM data for a read appears one cycle later, so the valid is too.
      rvalid0_r <= access0_s & ~bus.Wren0;
      rvalid1_r <= access1_s & ~bus.Wren1;
    end
  end

  // RAM port mux: owner's request passes straight through, otherwise all zero.
  always_comb begin
    ram_addr_s  = 5'd0;
    ram_wdata_s = 8'd0;
    ram_wren_s  = 1'b0;
    if (access0_s) begin
      ram_addr_s  = bus.Addr0;
      ram_wdata_s = bus.Wdata0;
      ram_wren_s  = bus.Wren0;
    end else if (access1_s) begin
      ram_addr_s  = bus.Addr1;
      ram_wdata_s = bus.Wdata1;
      ram_wren_s  = bus.Wren1;
    end else begin
      ram_addr_s  = 5'd0;
      ram_wdata_s = 8'd0;
      ram_wren_s  = 1'b0;
    end
  end

  assign bus.Gnt0      = gnt0_r;
  assign bus.Gnt1      = gnt1_r;
  assign bus.Ram_Addr  = ram_addr_s;
  assign bus.Ram_Wdata = ram_wdata_s;
  assign bus.Ram_Wren  = ram_wren_s;
  assign bus.Rdata     = bus.Ram_Rdata;
  assign bus.Rvalid0   = rvalid0_r;
  assign bus.Rvalid1   = rvalid1_r;

endmodule
